// File: rtl/ser_ready_sequencer.sv
// rtl/ser_ready_sequencer.sv - walks a layer's neurons in order, offering each one once its ready bit is set
//
// Optional feature macro: SER_READY_TIMEOUT_EN
//   When it is defined, a neuron that stays un-transferred for TIMEOUT_CYCLES
//   SCAN cycles is skipped, and its bit is set in o_skip_mask.
//   When it is undefined, the sequencer waits indefinitely and o_skip_mask stays 0.
//
// Ports:
//   i_clk                      clock, rising edge
//   i_rst_n                    synchronous active-low reset
//   i_start                    request a pass; accepted only in IDLE when i_layer_id == LAYER_ID
//   i_layer_id[31:0]           layer currently being serialized
//   i_next_layer_output_ready  per-neuron ready bits (NUM_NEURON wide)
//   i_take                     consumer accepts the offered neuron
//   o_ready                    current neuron is ready and offered (SCAN only)
//   o_neuron_id[31:0]          current or last neuron index, zero-extended
//   o_busy                     pass in progress (SCAN or DONE)
//   o_done                     one-cycle pulse when the pass completes
//   o_skip_mask                sticky per-neuron timeout flags (NUM_NEURON wide)
module ser_ready_sequencer #(
  parameter int LAYER_ID       = 1,
  parameter int NUM_NEURON     = 30,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [31:0]           i_layer_id,
  input  logic [NUM_NEURON-1:0] i_next_layer_output_ready,
  input  logic                  i_take,
  output logic                  o_ready,
  output logic [31:0]           o_neuron_id,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [NUM_NEURON-1:0] o_skip_mask
);

  localparam int IDX_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURON - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic start_ok;
  logic xfer;
  logic timeout;
  logic advance;

  assign start_ok = (state_q == IDLE) && i_start && (i_layer_id == 32'(LAYER_ID));
  assign xfer     = (state_q == SCAN) && i_next_layer_output_ready[idx_q] && i_take;
  // A timeout only matters when no transfer happens in the same cycle;
  // a simultaneous transfer wins and leaves the skip bit clear.
  assign advance  = xfer || timeout;

`ifdef SER_READY_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0]           cnt_q, cnt_d;
  logic [NUM_NEURON-1:0] mask_q, mask_d;

  // Fires on the TIMEOUT_CYCLES-th waiting cycle at the current index,
  // so a stuck neuron occupies exactly TIMEOUT_CYCLES SCAN cycles.
  assign timeout = (state_q == SCAN) && !xfer && (cnt_q == TO_LAST);

  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q;
    if (start_ok) begin
      cnt_d  = '0;
      mask_d = '0;
    end else if (state_q == SCAN) begin
      if (advance) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      if (timeout) begin
        mask_d[idx_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end

  assign o_skip_mask = mask_q;
`else
  assign timeout     = 1'b0;
  assign o_skip_mask = '0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    o_ready = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        o_ready = i_next_layer_output_ready[idx_q];
        if (advance) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // The index is left untouched in DONE and IDLE, so the last neuron stays visible.
  assign o_neuron_id = {{(32 - IDX_W){1'b0}}, idx_q};
  assign o_busy      = (state_q != IDLE);

endmodule
